// File: rtl/wb_mem_param.sv
// Parametrised Wishbone-style single-port memory slave with byte-lane writes,
// programmable wait states, out-of-range error response and a post-reset init sweep.
module wb_mem_param #(
    parameter int              DW          = 32,
    parameter int              AW          = 8,
    parameter int              DEPTH       = 256,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [DW-1:0]   INIT_VAL    = {DW/8{8'h11}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strb,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   sel,
    output logic [DW-1:0]     rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int              NB        = DW / 8;
    localparam int              IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_CMP = (AW+1)'(DEPTH);
    localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [NB-1:0]      sel_q;
    logic               ack_q;
    logic               err_q;
    logic               busy_q;

    logic               req_we;
    logic [AW-1:0]      req_addr;
    logic               req_in_range;
    logic               enter_resp;
    logic               rd_en;
    logic [IW-1:0]      rd_idx;

    logic               cap_in_range;
    logic               mem_we;
    logic [IW-1:0]      mem_idx;
    logic [NB-1:0]      mem_be;
    logic [DW-1:0]      mem_wdata;

    // With zero wait states the request goes straight from the bus pins into RESP.
    always_comb begin
        req_we       = we_q;
        req_addr     = addr_q;
        if (state_q == S_IDLE) begin
            req_we   = we;
            req_addr = addr;
        end
        req_in_range = ({1'b0, req_addr} < DEPTH_CMP);
        enter_resp   = !rst && (((state_q == S_IDLE) && strb && (WAIT_CYCLES == 0)) ||
                                ((state_q == S_WAIT) && (cnt_q == 4'd0)));
        rd_en        = enter_resp && !req_we && req_in_range;
        rd_idx       = req_addr[IW-1:0];
    end

    // Single write port shared by the init sweep and committed bus writes.
    always_comb begin
        cap_in_range = ({1'b0, addr_q} < DEPTH_CMP);
        mem_we       = 1'b0;
        mem_idx      = addr_q[IW-1:0];
        mem_be       = sel_q;
        mem_wdata    = wdata_q;
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_we    = 1'b1;
                mem_idx   = ptr_q;
                mem_be    = '1;
                mem_wdata = INIT_VAL;
            end else if ((state_q == S_RESP) && we_q && cap_in_range) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            ack_q <= enter_resp && req_in_range;
            err_q <= enter_resp && !req_in_range;
            case (state_q)
                S_INIT: begin
                    busy_q <= 1'b1;
                    ptr_q  <= ptr_q + 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (strb) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        sel_q   <= sel;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // One narrow RAM per byte lane so each lane's write enable maps onto its own array.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (mem_we && mem_be[gi]) begin
                    lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || !rd_en) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= lane_mem[rd_idx];
                end
            end

            assign rdata[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_wb_mem_param.sv
// Directed self-checking bench for wb_mem_param: DEPTH=200 with two wait states,
// plus a zero-wait-state instance for the back-to-back timing checks.
module tb_wb_mem_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, strb, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  sel;
    logic        ack, err, busy;

    logic        rst_z, strb_z, we_z;
    logic [7:0]  addr_z;
    logic [31:0] wdata_z, rdata_z;
    logic [3:0]  sel_z;
    logic        ack_z, err_z, busy_z;

    int checks   = 0;
    int failures = 0;

    wb_mem_param #(
        .DW(32), .AW(8), .DEPTH(200), .WAIT_CYCLES(2), .INIT_VAL(32'h11111111)
    ) u_dut (
        .clk(clk), .rst(rst), .strb(strb), .we(we), .addr(addr), .wdata(wdata),
        .sel(sel), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    wb_mem_param #(
        .DW(32), .AW(8), .DEPTH(200), .WAIT_CYCLES(0), .INIT_VAL(32'h11111111)
    ) u_dut_z (
        .clk(clk), .rst(rst_z), .strb(strb_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
        .sel(sel_z), .rdata(rdata_z), .ack(ack_z), .err(err_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on the wait-state instance; strb is dropped once accepted.
    task automatic txn(input string tag, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic exp_err, input logic [31:0] exp_rd);
        int n;
        n = 0;
        strb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        do begin
            tick();
            n++;
            if (n == 1) strb = 1'b0;
        end while (!(ack || err) && n < 20);
        $display("txn %s we=%0b addr=%0d ack=%0b err=%0b rdata=%h lat=%0d",
                 tag, w, a, ack, err, rdata, n);
        check({tag, "_lat"}, 64'(n), 64'd3);
        check({tag, "_ack"}, 64'(ack), 64'(!exp_err));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
        tick();
        check({tag, "_pulse"}, 64'({ack, err}), 64'd0);
    endtask

    // Counts cycles from rst release until busy falls, flagging any stray response.
    task automatic sweep(input string tag);
        int n;
        int stray;
        n = 0;
        stray = 0;
        do begin
            tick();
            n++;
            if (ack || err) stray++;
        end while (busy && n < 300);
        $display("txn %s sweep_cycles=%0d stray=%0d", tag, n, stray);
        check({tag, "_busy_fall"}, 64'(n), 64'd200);
        check({tag, "_stray"}, 64'(stray), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        int first;
        int t[3];
        logic [31:0] dv[3];

        rst = 1'b1; strb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        rst_z = 1'b1; strb_z = 1'b0; we_z = 1'b0; addr_z = '0; wdata_z = '0; sel_z = '0;

        // 1: reset state, sweep length, first read
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_outs", 64'({ack, err}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        rst_z = 1'b0;
        sweep("s1");
        txn("s1_rd5", 1'b0, 8'd5, 32'h0, 4'h0, 1'b0, 32'h11111111);

        // 2: byte-lane writes
        txn("s2_wr_full", 1'b1, 8'd10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
        txn("s2_wr_part", 1'b1, 8'd10, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
        txn("s2_rd", 1'b0, 8'd10, 32'h0, 4'h0, 1'b0, 32'hDEBBBEDD);
        txn("s2_wr_sel0", 1'b1, 8'd10, 32'h00000000, 4'b0000, 1'b0, 32'h0);
        txn("s2_rd_sel0", 1'b0, 8'd10, 32'h0, 4'h0, 1'b0, 32'hDEBBBEDD);

        // 3: out-of-range accesses and the top in-range word
        txn("s3_rd200", 1'b0, 8'd200, 32'h0, 4'h0, 1'b1, 32'h0);
        txn("s3_wr255", 1'b1, 8'd255, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0);
        txn("s3_rd199", 1'b0, 8'd199, 32'h0, 4'h0, 1'b0, 32'h11111111);

        // 4: strb held through reset and sweep
        strb = 1'b1; we = 1'b0; addr = 8'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        first = -1;
        while (first < 0 && n < 300) begin
            tick();
            n++;
            if (ack || err) begin
                first = n;
                strb = 1'b0;
            end
        end
        $display("txn s4_held_rd3 ack=%0b err=%0b rdata=%h at_cycle=%0d", ack, err, rdata, first);
        check("s4_ack_cycle", 64'(first), 64'd203);
        check("s4_ack", 64'({ack, err}), 64'b10);
        check("s4_rdata", 64'(rdata), 64'h11111111);
        tick();
        check("s4_pulse", 64'({ack, err}), 64'd0);

        // 5: reset during WAIT discards the write
        strb = 1'b1; we = 1'b1; addr = 8'd7; wdata = 32'h12345678; sel = 4'hF;
        tick();
        strb = 1'b0;
        check("s5_wait_noack", 64'({ack, err}), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_busy", 64'(busy), 64'd1);
        check("s5_noack", 64'({ack, err}), 64'd0);
        sweep("s5");
        txn("s5_rd7", 1'b0, 8'd7, 32'h0, 4'h0, 1'b0, 32'h11111111);

        // 6a: held strb, reads of 0,1,2 with two wait states
        txn("s6_wr0", 1'b1, 8'd0, 32'hA0A0A0A0, 4'hF, 1'b0, 32'h0);
        txn("s6_wr1", 1'b1, 8'd1, 32'hA1A1A1A1, 4'hF, 1'b0, 32'h0);
        txn("s6_wr2", 1'b1, 8'd2, 32'hA2A2A2A2, 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            t[i] = -1;
            dv[i] = '0;
        end
        strb = 1'b1; we = 1'b0; addr = 8'd0;
        n = 0;
        k = 0;
        while (k < 3 && n < 40) begin
            tick();
            n++;
            if (ack) begin
                t[k] = n;
                dv[k] = rdata;
                $display("txn s6_held_rd%0d ack_cycle=%0d rdata=%h", k, n, rdata);
                k++;
                addr = 8'(k);
                if (k == 3) strb = 1'b0;
            end
        end
        check("s6_t0", 64'(t[0]), 64'd3);
        check("s6_t1", 64'(t[1]), 64'd7);
        check("s6_t2", 64'(t[2]), 64'd11);
        check("s6_d0", 64'(dv[0]), 64'hA0A0A0A0);
        check("s6_d1", 64'(dv[1]), 64'hA1A1A1A1);
        check("s6_d2", 64'(dv[2]), 64'hA2A2A2A2);
        tick();
        check("s6_pulse", 64'({ack, err}), 64'd0);

        // 6b: zero wait states, write then back-to-back read-back
        check("z_busy", 64'(busy_z), 64'd0);
        strb_z = 1'b1; we_z = 1'b1; addr_z = 8'd1; wdata_z = 32'hCAFE0001; sel_z = 4'hF;
        tick();
        $display("txn z_wr1 ack=%0b err=%0b rdata=%h", ack_z, err_z, rdata_z);
        check("z_wr_ack", 64'({ack_z, err_z}), 64'b10);
        we_z = 1'b0;
        tick();
        check("z_gap", 64'(ack_z), 64'd0);
        tick();
        $display("txn z_rd1 ack=%0b err=%0b rdata=%h", ack_z, err_z, rdata_z);
        check("z_rd_ack", 64'(ack_z), 64'd1);
        check("z_rd_data", 64'(rdata_z), 64'hCAFE0001);
        strb_z = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            t[i] = -1;
            dv[i] = '0;
        end
        strb_z = 1'b1; we_z = 1'b0; addr_z = 8'd0;
        n = 0;
        k = 0;
        while (k < 3 && n < 20) begin
            tick();
            n++;
            if (ack_z) begin
                t[k] = n;
                dv[k] = rdata_z;
                $display("txn z_held_rd%0d ack_cycle=%0d rdata=%h", k, n, rdata_z);
                k++;
                addr_z = 8'(k);
                if (k == 3) strb_z = 1'b0;
            end
        end
        check("z_t0", 64'(t[0]), 64'd1);
        check("z_t1", 64'(t[1]), 64'd3);
        check("z_t2", 64'(t[2]), 64'd5);
        check("z_d0", 64'(dv[0]), 64'h11111111);
        check("z_d1", 64'(dv[1]), 64'hCAFE0001);
        check("z_d2", 64'(dv[2]), 64'h11111111);
        tick();
        check("z_pulse", 64'({ack_z, err_z}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
